// File: rtl/toggle_sync_sched.sv
// Source-domain scheduler sharing one toggle-pulse CDC channel among N_REQ requesters.
// Per-requester event counters feed a round-robin arbiter that issues pulses GAP cycles apart.
module toggle_sync_sched #(
  parameter  int N_REQ = 4,
  parameter  int CNT_W = 4,
  parameter  int GAP   = 6,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             ovf_clr,
  output logic             xfer_pulse,
  output logic [ID_W-1:0]  xfer_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow,
  output logic             busy
);

  localparam int               GAP_W    = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt [N_REQ];
  logic [N_REQ-1:0]   r_ovf;
  logic [ID_W-1:0]    r_rr;
  logic [ID_W-1:0]    r_xfer_id;
  logic               r_xfer_pulse;
  logic [GAP_W-1:0]   r_gap;

  logic [N_REQ-1:0]   w_pend;
  logic [N_REQ-1:0]   w_dec;
  logic [N_REQ-1:0]   w_ovf_set;
  logic [2*N_REQ-1:0] w_rot;
  logic               w_any;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_rr_next;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_pend    = '0;
    w_dec     = '0;
    w_ovf_set = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pend[i]    = (r_cnt[i] != '0);
      w_dec[i]     = (r_state == S_ISSUE) && (r_xfer_id == ID_W'(i));
      w_ovf_set[i] = req_pulse[i] && !w_dec[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  // Rotate the pending vector so bit 0 is the RR pointer; first set bit is the winner.
  always_comb begin
    int v_off;
    int v_sum;
    w_rot = {w_pend, w_pend} >> r_rr;
    w_any = 1'b0;
    v_off = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        v_off = k;
      end
    end
    v_sum = int'(r_rr) + v_off;
    if (v_sum >= N_REQ) v_sum = v_sum - N_REQ;
    w_win = ID_W'(v_sum);
  end

  assign w_rr_next = (r_xfer_id == ID_W'(N_REQ - 1)) ? '0 : r_xfer_id + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is plain flops, not RAM, so it is cleared by reset like any register.
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_pulse[i] && !w_dec[i]) begin
          if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !req_pulse[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
      // A fresh overflow beats a simultaneous clear.
      r_ovf <= w_ovf_set | (r_ovf & ~{N_REQ{ovf_clr}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr         <= '0;
      r_xfer_id    <= '0;
      r_xfer_pulse <= 1'b0;
      r_gap        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state      <= S_ISSUE;
            r_xfer_id    <= w_win;
            r_xfer_pulse <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state      <= S_HOLD;
          r_xfer_pulse <= 1'b0;
          r_rr         <= w_rr_next;
          r_gap        <= GAP_LOAD;
        end
        S_HOLD: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (w_any) begin
            r_state      <= S_ISSUE;
            r_xfer_id    <= w_win;
            r_xfer_pulse <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign xfer_pulse = r_xfer_pulse;
  assign xfer_id    = r_xfer_id;
  assign pending    = w_pend;
  assign overflow   = r_ovf;
  assign busy       = (r_state != S_IDLE) || (|w_pend);

endmodule

// File: tb/tb_toggle_sync_sched.sv
// Bench for toggle_sync_sched: directed steps plus random traffic, checked every cycle
// against a timing-rule model (issue allowed GAP cycles after the previous issue).
module tb_toggle_sync_sched;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int GAP  = 6;
  localparam int IW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_pulse;
  logic          ovf_clr;
  logic          xfer_pulse;
  logic [IW-1:0] xfer_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;
  logic          busy;

  always #5 clk = ~clk;

  toggle_sync_sched #(.N_REQ(N), .CNT_W(CW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_pulse(req_pulse), .ovf_clr(ovf_clr),
    .xfer_pulse(xfer_pulse), .xfer_id(xfer_id), .pending(pending),
    .overflow(overflow), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: event counts, sticky flags, RR pointer and time of last issue.
  int       m_cnt [N];
  logic [N-1:0] m_ovf;
  int       m_rr, m_last, m_id, cyc;
  bit       m_pulse;
  int       acc [N];
  int       got [N];
  int       waitc [N];
  int       dut_last;
  int       log_cyc [$];
  int       log_id [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (m_cnt[j] != 0) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; acc[i] = 0; got[i] = 0; waitc[i] = 0;
    end
    m_ovf = '0; m_rr = 0; m_last = -1000; m_id = 0; m_pulse = 0;
    dut_last = -1;
    log_cyc.delete();
    log_id.delete();
  endtask

  task automatic model_step(input logic [N-1:0] r, input bit clr);
    int win;
    bit decide, inc, dec, lost;
    logic [N-1:0] nov;
    win    = rr_pick();
    decide = !m_pulse && (cyc + 1 - m_last >= GAP) && (win >= 0);
    nov    = '0;
    for (int i = 0; i < N; i++) begin
      inc  = r[i];
      dec  = m_pulse && (m_id == i);
      lost = inc && !dec && (m_cnt[i] == MAXC);
      if (inc && !lost) acc[i]++;
      if (lost) nov[i] = 1'b1;
      else if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) m_cnt[i]--;
    end
    m_ovf = nov | (m_ovf & ~{N{clr}});
    if (m_pulse) m_rr = (m_id + 1) % N;
    if (decide) begin
      m_pulse = 1'b1; m_id = win; m_last = cyc + 1;
    end else begin
      m_pulse = 1'b0;
    end
  endtask

  task automatic observe();
    logic [N-1:0] pend;
    for (int i = 0; i < N; i++) pend[i] = (m_cnt[i] != 0);
    check("xfer_pulse", xfer_pulse, m_pulse);
    check("xfer_id",    xfer_id,    m_id);
    check("pending",    pending,    pend);
    check("overflow",   overflow,   m_ovf);
    check("busy",       busy,       (cyc <= m_last + GAP - 1) || (|pend));
    if (xfer_pulse) begin
      log_cyc.push_back(cyc);
      log_id.push_back(int'(xfer_id));
      got[xfer_id]++;
      if (dut_last >= 0) check("spacing_ge_gap", (cyc - dut_last) >= GAP, 1);
      dut_last = cyc;
    end
    for (int i = 0; i < N; i++) begin
      if (xfer_pulse && xfer_id == IW'(i)) begin
        check("grant_wait", waitc[i] <= N * GAP, 1);
        waitc[i] = 0;
      end else if (pend[i]) begin
        waitc[i]++;
      end else begin
        waitc[i] = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic step(input logic [N-1:0] r, input bit clr = 1'b0, input bit rs = 1'b0);
    rst = rs; req_pulse = r; ovf_clr = clr;
    if (rs) model_reset();
    else    model_step(r, clr);
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  initial begin
    int t0, nb;
    cyc = 0;
    model_reset();

    // Reset, then a single event on requester 2.
    step('0, 0, 1);
    step('0, 0, 1);
    check("reset_id", xfer_id, 0);
    check("reset_busy", busy, 0);
    idle(8);
    t0 = cyc;
    step(4'b0100);
    idle(20);
    check("single_count", log_cyc.size(), 1);
    if (log_cyc.size() >= 1) begin
      check("single_cycle", log_cyc[0], t0 + 2);
      check("single_id", log_id[0], 2);
    end
    check("single_id_held", xfer_id, 2);

    // All four requesters at once: grants 0,1,2,3 spaced GAP apart.
    step('0, 0, 1);
    idle(4);
    t0 = cyc;
    step(4'b1111);
    idle(30);
    check("all4_count", log_cyc.size(), 4);
    for (int k = 0; k < 4 && k < log_cyc.size(); k++) begin
      check("all4_cycle", log_cyc[k], t0 + 2 + k * GAP);
      check("all4_id", log_id[k], k);
    end

    // Requester 1 held for 20 cycles: saturation and sticky overflow.
    step('0, 0, 1);
    t0 = cyc;
    for (int i = 0; i < 20; i++) step(4'b0010);
    check("sat_pending", pending, 4'b0010);
    idle(150);
    check("sat_overflow", overflow, 4'b0010);
    nb = 0;
    foreach (log_cyc[k]) if (log_cyc[k] < t0 + 20) nb++;
    check("sat_total", log_cyc.size(), 15 + nb);
    step('0, 1);
    check("ovf_clear", overflow, 4'b0000);

    // Increments on requester 0 colliding with its own grants.
    step('0, 0, 1);
    for (int i = 0; i < 4; i++) step(4'b0001);
    idle(40);
    check("incdec_no_ovf", overflow, 4'b0000);
    check("incdec_total", log_cyc.size(), 4);

    // Random traffic, density 0.5 per requester, then drain.
    step('0, 0, 1);
    for (int i = 0; i < 2000; i++)
      step(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 99) == 0);
    idle(500);
    for (int i = 0; i < N; i++) check("rand_pulses_eq_accepted", got[i], acc[i]);
    check("rand_drained", busy, 0);

    // Reset while in HOLD with five events pending: everything discarded.
    step('0, 0, 1);
    step(4'b1111);
    step(4'b0011);
    idle(3);
    check("hold_pending_before_rst", pending, 4'b1111);
    step('0, 0, 1);
    check("rst_pending", pending, 0);
    check("rst_pulse", xfer_pulse, 0);
    check("rst_busy", busy, 0);
    idle(50);
    check("rst_no_pulse", log_cyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
